fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter and instruction-fetch stage that sits directly upstream of the instruction decoder/controller.
//  It fetches 16-bit instructions from a synchronous-read instruction memory and presents Op = instr[15:12] to the controller.
//  It consumes the controller's branch/jump outputs to form the next PC.
//  Two-phase operation: FETCH (address out) then EXEC (instruction valid, decoded, PC updated). One instruction every 2 cycles.
// PARAMETERS
//  PC_W    8   PC / instruction-memory address width (4..12)
//  RST_PC  0   PC value loaded on reset
//  CNT_W   16  width of the retired-instruction counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  stall       in   1      hold in FETCH while high (memory not ready / single-step)
//  imem_addr   out  PC_W   instruction-memory address (registered)
//  imem_data   in   16     instruction word, valid the cycle after imem_addr is presented
//  branch      in   1      from controller: take conditional branch (sampled in EXEC only)
//  jump        in   1      from controller: take unconditional jump (sampled in EXEC only)
//  pc          out  PC_W   address of the instruction currently held in instr
//  instr       out  16     instruction register
//  op          out  4      instr[15:12], to controller Op input
//  instr_valid out  1      high in EXEC; downstream register/memory writes are qualified by it
//  halted      out  1      high once a HALT (op==4'hF) has executed
//  retired     out  CNT_W  count of instructions that completed EXEC
// BEHAVIOUR
//  Reset (rst=1 at posedge): state<=FETCH; pc<=RST_PC; imem_addr<=RST_PC; instr<=16'h0; instr_valid<=0; halted<=0; retired<=0.
//  rst has priority over all other inputs in every state, including EXEC and HALT.
//  States: FETCH -> EXEC -> FETCH ...; EXEC -> HALT when op==4'hF. HALT is terminal until rst.
//  FETCH:
//   - stall=1: remain in FETCH; no register changes.
//   - stall=0: instr<=imem_data; pc<=imem_addr; go to EXEC.
//  EXEC:
//   - instr_valid=1 for exactly this one cycle. The controller decodes op combinationally; branch/jump are sampled at the end of the cycle.
//   - Next PC priority, highest first:
//       op==4'hF: hold, enter HALT.
//       jump=1: instr[PC_W-1:0]. Jump target is the low bits of instr[11:0]; upper bits are zero when PC_W>12.
//       branch=1: pc + 1 + sext(instr[3:0]) (offset range -8..+7).
//       otherwise: pc + 1.
//   - All next-PC arithmetic is modulo 2^PC_W. Wrap from max to 0 is silent.
//   - imem_addr<=nextPC; retired<=retired+1 (wraps modulo 2^CNT_W); go to FETCH.
//   - stall is ignored in EXEC.
//   - If jump and branch are both high, jump wins.
//  HALT: halted=1; instr_valid=0; pc, imem_addr, instr and retired frozen; stall, branch and jump ignored.
//   - The HALT instruction itself is counted in retired.
//  instr_valid=0 in FETCH and HALT. branch/jump are don't-care outside EXEC.
//  op is always instr[15:12]; after reset it reads 0 while instr_valid=0.
//  Reset mid-EXEC: the current instruction is discarded and not counted; the next fetch is from RST_PC.
//  Latency: reset release -> first instr_valid = 2 cycles (with stall=0).
// TESTING
//  1. Reset, ROM 0..3 = ADD-type (op 0), stall=0 -> imem_addr 0,1,2,3 on alternate cycles; instr_valid toggles; retired=4 after 8 cycles.
//  2. pc=5, instr=16'hD00E, branch=1 -> next imem_addr = 5+1-2 = 4. With branch=0 -> 6.
//  3. pc=2, instr=16'h7025, jump=1, branch=1 -> next imem_addr=8'h25 (jump priority).
//  4. PC_W=8, pc=8'hFF, no branch/jump -> next imem_addr=8'h00; retired increments.
//  5. stall held high 3 cycles in FETCH -> instr, pc and retired unchanged; instr_valid=0; resumes on stall=0.
//  6. Execute 16'hF000 -> halted=1 and retired frozen. Assert rst during EXEC of another program -> instr_valid=0 next cycle; imem_addr=RST_PC; retired=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage. Two-phase operation: FETCH
// presents imem_addr and captures the returned word; EXEC exposes the
// instruction to the controller for one cycle and forms the next PC from
// its branch/jump decision. A HALT opcode (4'hF) freezes the stage until rst.
module fetch_unit #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0,
  parameter int              CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_data,
  input  logic             branch,
  input  logic             jump,
  output logic [PC_W-1:0]  pc,
  output logic [15:0]      instr,
  output logic [3:0]       op,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t           state, state_d;
  logic [PC_W-1:0]  pc_d, addr_d;
  logic [15:0]      instr_d;
  logic [CNT_W-1:0] retired_d;

  // Jump target is instr[11:0] truncated or zero-extended to PC_W; the branch
  // offset is instr[3:0] sign-extended. Extending into a wide temporary first
  // keeps both legal for every PC_W in 4..12 and beyond.
  logic [PC_W+11:0] jump_ext;
  logic [PC_W+3:0]  off_ext;
  logic [PC_W-1:0]  jump_tgt, pc_inc, branch_tgt;

  assign jump_ext   = {{PC_W{1'b0}}, instr[11:0]};
  assign off_ext    = {{PC_W{instr[3]}}, instr[3:0]};
  assign jump_tgt   = jump_ext[PC_W-1:0];
  assign pc_inc     = pc + PC_W'(1);
  assign branch_tgt = pc_inc + off_ext[PC_W-1:0];

  assign op          = instr[15:12];
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

  // Next-state and next-register values for the FETCH/EXEC/HALT sequencer.
  // NOTE: every signal gets a hold value before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    addr_d    = imem_addr;
    instr_d   = instr;
    retired_d = retired;
    case (state)
      FETCH: begin
        if (!stall) begin
          instr_d = imem_data;
          pc_d    = imem_addr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        retired_d = retired + CNT_W'(1);
        if (op == 4'hF) begin
          state_d = HALT;
        end else begin
          if (jump)        addr_d = jump_tgt;
          else if (branch) addr_d = branch_tgt;
          else             addr_d = pc_inc;
          state_d = FETCH;
        end
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  // State and datapath registers; synchronous reset overrides every state.
  // NOTE: non-blocking assignments so all registers update from the same
  // pre-edge values, matching the hardware they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RST_PC;
      imem_addr <= RST_PC;
      instr     <= 16'h0000;
      retired   <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_addr <= addr_d;
      instr     <= instr_d;
      retired   <= retired_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (PC_W=8). The instruction memory is a
// table indexed by the registered imem_addr, so the word is valid in the
// cycle after the address is presented. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_fetch_unit;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic             branch = 1'b0;
  logic             jump = 1'b0;
  logic [PC_W-1:0]  imem_addr;
  logic [15:0]      imem_data;
  logic [PC_W-1:0]  pc;
  logic [15:0]      instr;
  logic [3:0]       op;
  logic             instr_valid;
  logic             halted;
  logic [CNT_W-1:0] retired;

  logic [15:0] rom [0:(1<<PC_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];

  fetch_unit #(.PC_W(PC_W), .RST_PC(8'h00), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .branch      (branch),
    .jump        (jump),
    .pc          (pc),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; branch = 1'b0; jump = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // From FETCH: one edge into EXEC, drive the controller decision, one edge back.
  task automatic run_instr(input logic br, input logic jp);
    step();
    branch = br; jump = jp;
    step();
    branch = 1'b0; jump = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1<<PC_W); i++) rom[i] = 16'h0000;
  endtask

  initial begin
    clear_rom();

    // 1. Reset state, then four sequential op-0 instructions.
    rom[0] = 16'h0001; rom[1] = 16'h0102; rom[2] = 16'h0203; rom[3] = 16'h0304;
    do_reset();
    check("rst_addr",    imem_addr,   32'h0);
    check("rst_pc",      pc,          32'h0);
    check("rst_instr",   instr,       32'h0);
    check("rst_op",      op,          32'h0);
    check("rst_valid",   instr_valid, 32'h0);
    check("rst_halted",  halted,      32'h0);
    check("rst_retired", retired,     32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("seq_valid_exec", instr_valid, 32'h1);
      check("seq_pc",         pc,          i);
      check("seq_instr",      instr,       {16'h0, rom[i]});
      check("seq_op",         op,          32'h0);
      step();
      check("seq_valid_fetch", instr_valid, 32'h0);
      check("seq_addr",        imem_addr,   i + 1);
    end
    check("seq_retired", retired, 32'h4);

    // 2. Branch with negative offset, then fall-through, positive offset.
    clear_rom();
    rom[0] = 16'h7005; rom[5] = 16'hD00E;
    do_reset();
    run_instr(1'b0, 1'b1);
    check("jmp_to_5", imem_addr, 32'h05);
    run_instr(1'b1, 1'b0);
    check("br_neg", imem_addr, 32'h04);
    check("br_retired", retired, 32'h2);
    do_reset();
    run_instr(1'b0, 1'b1);
    run_instr(1'b0, 1'b0);
    check("br_not_taken", imem_addr, 32'h06);
    rom[6] = 16'h1007;
    run_instr(1'b1, 1'b0);
    check("br_pos", imem_addr, 32'h0E);

    // 3. Jump wins over branch.
    clear_rom();
    rom[0] = 16'h7002; rom[2] = 16'h7025;
    do_reset();
    run_instr(1'b0, 1'b1);
    check("jmp_to_2", imem_addr, 32'h02);
    run_instr(1'b1, 1'b1);
    check("jmp_priority", imem_addr, 32'h25);

    // 4. PC wrap from 0xFF to 0x00.
    clear_rom();
    rom[0] = 16'h70FF;
    do_reset();
    run_instr(1'b0, 1'b1);
    check("jmp_to_ff", imem_addr, 32'hFF);
    run_instr(1'b0, 1'b0);
    check("wrap_addr",    imem_addr, 32'h00);
    check("wrap_retired", retired,   32'h2);

    // 5. Stall holds FETCH; stall ignored in EXEC.
    clear_rom();
    rom[0] = 16'h0123; rom[1] = 16'h0456;
    do_reset();
    run_instr(1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr",   instr,       32'h0123);
      check("stall_pc",      pc,          32'h0);
      check("stall_retired", retired,     32'h1);
      check("stall_valid",   instr_valid, 32'h0);
    end
    stall = 1'b0;
    step();
    check("resume_valid", instr_valid, 32'h1);
    check("resume_instr", instr,       32'h0456);
    check("resume_pc",    pc,          32'h1);
    stall = 1'b1;
    step();
    check("exec_stall_addr",    imem_addr, 32'h2);
    check("exec_stall_retired", retired,   32'h2);
    stall = 1'b0;

    // 6. HALT freezes the stage; reset mid-EXEC discards the instruction.
    clear_rom();
    rom[1] = 16'hF000;
    do_reset();
    run_instr(1'b0, 1'b0);
    step();
    check("halt_op",    op,          32'hF);
    check("halt_valid", instr_valid, 32'h1);
    step();
    check("halted",        halted,      32'h1);
    check("halt_valid0",   instr_valid, 32'h0);
    check("halt_retired",  retired,     32'h2);
    stall = 1'b1; branch = 1'b1; jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frozen_retired", retired,   32'h2);
      check("frozen_addr",    imem_addr, 32'h1);
      check("frozen_pc",      pc,        32'h1);
      check("frozen_instr",   instr,     32'hF000);
      check("frozen_halted",  halted,    32'h1);
    end
    clear_rom();
    rom[0] = 16'h0011; rom[1] = 16'h0022;
    do_reset();
    check("unhalt", halted, 32'h0);
    run_instr(1'b0, 1'b0);
    step();
    check("pre_rst_valid", instr_valid, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midexec_valid",   instr_valid, 32'h0);
    check("midexec_addr",    imem_addr,   32'h0);
    check("midexec_retired", retired,     32'h0);
    step();
    check("refetch_pc",    pc,    32'h0);
    check("refetch_instr", instr, 32'h0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
